// File: rtl/wb_master_if_pkg.sv
// Shared types and constants for the OpenMIPS-to-Wishbone memory port bridge.
package wb_master_if_pkg;

  // Bridge states; 2'b10 is unused and recovers to idle.
  typedef enum logic [1:0] {
    WB_IDLE           = 2'b00,
    WB_BUSY           = 2'b01,
    WB_WAIT_FOR_STALL = 2'b11
  } wb_state_e;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  // Index into the pipeline stall vector for each memory port.
  localparam int STALL_IF  = 1;
  localparam int STALL_MEM = 4;

endpackage

// File: rtl/wb_master_if_if.sv
// Wishbone B3 classic master-side signal bundle between the bridge and wb_conmax.
interface wb_master_if_if;

  logic [31:0] wishbone_data_i;
  logic        wishbone_ack_i;
  logic [31:0] wishbone_addr_o;
  logic [31:0] wishbone_data_o;
  logic        wishbone_we_o;
  logic [3:0]  wishbone_sel_o;
  logic        wishbone_stb_o;
  logic        wishbone_cyc_o;

  modport master (
    input  wishbone_data_i,
    input  wishbone_ack_i,
    output wishbone_addr_o,
    output wishbone_data_o,
    output wishbone_we_o,
    output wishbone_sel_o,
    output wishbone_stb_o,
    output wishbone_cyc_o
  );

  modport slave (
    output wishbone_data_i,
    output wishbone_ack_i,
    input  wishbone_addr_o,
    input  wishbone_data_o,
    input  wishbone_we_o,
    input  wishbone_sel_o,
    input  wishbone_stb_o,
    input  wishbone_cyc_o
  );

endinterface

// File: rtl/wb_master_if.sv
// Bridges one OpenMIPS memory port to a Wishbone B3 classic master.
// Optional bus timeout is built when WB_TIMEOUT_EN is defined.
//
// state             | meaning
// WB_IDLE           | no bus cycle; accept a new CPU request
// WB_BUSY           | stb/cyc asserted, waiting for ack (or flush/timeout)
// WB_WAIT_FOR_STALL | access done, holding read data until the stage unstalls
module wb_master_if
  import wb_master_if_pkg::*;
#(
  parameter int          STALL_BIT      = STALL_IF,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            stall_i,
  input  logic                  flush_i,
  input  logic                  cpu_ce_i,
  input  logic [31:0]           cpu_data_i,
  input  logic [31:0]           cpu_addr_i,
  input  logic                  cpu_we_i,
  input  logic [3:0]            cpu_sel_i,
  output logic [31:0]           cpu_data_o,
  output logic                  stallreq_o,
  wb_master_if_if.master        wb,
  output logic                  bus_err_o
);

  wb_state_e   state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic        stb_q, stb_d;
  logic        cyc_q, cyc_d;
  logic [31:0] rd_buf_q, rd_buf_d;

  logic        stage_stalled;
  logic        start;
  logic        tmo;

  assign stage_stalled = stall_i[STALL_BIT];
  assign start         = cpu_ce_i && !flush_i;

  // Only one stall bit matters to this port; the rest are intentionally ignored.
  logic unused_stall;
  assign unused_stall = ^stall_i;

`ifdef WB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;

  assign tmo = (state_q == WB_BUSY) && !flush_i && !wb.wishbone_ack_i &&
               (cnt_q == 16'(TIMEOUT_CYCLES));

  // Count BUSY cycles; held at zero outside BUSY so each access starts fresh.
  always_comb begin
    cnt_d = 16'd0;
    if (state_q == WB_BUSY) cnt_d = cnt_q + 16'd1;
  end

  // Timeout counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 16'd0;
    else     cnt_q <= cnt_d;
  end
`else
  assign tmo = 1'b0;

  logic unused_tmo;
  assign unused_tmo = ^32'(TIMEOUT_CYCLES);
`endif

  assign bus_err_o = tmo;

  // Next-state and next bus values.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    we_d     = we_q;
    sel_d    = sel_q;
    stb_d    = stb_q;
    cyc_d    = cyc_q;
    rd_buf_d = rd_buf_q;
    case (state_q)
      WB_IDLE: begin
        if (start) begin
          state_d  = WB_BUSY;
          addr_d   = cpu_addr_i;
          data_d   = cpu_data_i;
          we_d     = cpu_we_i;
          sel_d    = cpu_sel_i;
          stb_d    = 1'b1;
          cyc_d    = 1'b1;
          rd_buf_d = ZeroWord;
        end
      end
      WB_BUSY: begin
        if (flush_i || wb.wishbone_ack_i || tmo) begin
          addr_d = ZeroWord;
          data_d = ZeroWord;
          we_d   = 1'b0;
          sel_d  = 4'h0;
          stb_d  = 1'b0;
          cyc_d  = 1'b0;
          if (flush_i) begin
            state_d  = WB_IDLE;
            rd_buf_d = ZeroWord;
          end else begin
            state_d = stage_stalled ? WB_WAIT_FOR_STALL : WB_IDLE;
            // Timed-out accesses return zero; writes keep the buffer.
            if (tmo)        rd_buf_d = ZeroWord;
            else if (!we_q) rd_buf_d = wb.wishbone_data_i;
          end
        end
      end
      WB_WAIT_FOR_STALL: begin
        if (flush_i) begin
          state_d  = WB_IDLE;
          rd_buf_d = ZeroWord;
        end else if (!stage_stalled) begin
          state_d = WB_IDLE;
        end
      end
      default: begin
        state_d = WB_IDLE;
        addr_d  = ZeroWord;
        data_d  = ZeroWord;
        we_d    = 1'b0;
        sel_d   = 4'h0;
        stb_d   = 1'b0;
        cyc_d   = 1'b0;
      end
    endcase
  end

  // FSM state and registered bus outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= WB_IDLE;
      addr_q   <= ZeroWord;
      data_q   <= ZeroWord;
      we_q     <= 1'b0;
      sel_q    <= 4'h0;
      stb_q    <= 1'b0;
      cyc_q    <= 1'b0;
      rd_buf_q <= ZeroWord;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      stb_q    <= stb_d;
      cyc_q    <= cyc_d;
      rd_buf_q <= rd_buf_d;
    end
  end

  // Stall request and read data are combinational so an ack releases the pipe in the same cycle.
  always_comb begin
    stallreq_o = 1'b0;
    cpu_data_o = ZeroWord;
    case (state_q)
      WB_IDLE: begin
        stallreq_o = start;
        cpu_data_o = start ? ZeroWord : rd_buf_q;
      end
      WB_BUSY: begin
        stallreq_o = !(wb.wishbone_ack_i || tmo);
        if (wb.wishbone_ack_i && !we_q) cpu_data_o = wb.wishbone_data_i;
      end
      WB_WAIT_FOR_STALL: begin
        cpu_data_o = rd_buf_q;
      end
      default: begin
        stallreq_o = 1'b0;
        cpu_data_o = ZeroWord;
      end
    endcase
  end

  assign wb.wishbone_addr_o = addr_q;
  assign wb.wishbone_data_o = data_q;
  assign wb.wishbone_we_o   = we_q;
  assign wb.wishbone_sel_o  = sel_q;
  assign wb.wishbone_stb_o  = stb_q;
  assign wb.wishbone_cyc_o  = cyc_q;

endmodule

// File: tb/tb_wb_master_if.sv
// Randomized plus directed bench for wb_master_if against a transaction-level model.
module tb_wb_master_if;
  import wb_master_if_pkg::*;

  localparam int TMO = 8;
`ifdef WB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall_i;
  logic        flush_i;
  logic        cpu_ce_i;
  logic [31:0] cpu_data_i;
  logic [31:0] cpu_addr_i;
  logic        cpu_we_i;
  logic [3:0]  cpu_sel_i;
  logic [31:0] cpu_data_o;
  logic        stallreq_o;
  logic        bus_err_o;

  wb_master_if_if wb ();

  wb_master_if #(
    .STALL_BIT      (STALL_IF),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .cpu_ce_i   (cpu_ce_i),
    .cpu_data_i (cpu_data_i),
    .cpu_addr_i (cpu_addr_i),
    .cpu_we_i   (cpu_we_i),
    .cpu_sel_i  (cpu_sel_i),
    .cpu_data_o (cpu_data_o),
    .stallreq_o (stallreq_o),
    .wb         (wb),
    .bus_err_o  (bus_err_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: an outstanding bus access, a held result, and the captured request.
  bit          m_pending;
  bit          m_holding;
  logic [31:0] m_adr, m_dat, m_buf;
  logic        m_we;
  logic [3:0]  m_sel;
  int          m_busy_cycles;
  int          stb_seen;
  int          err_seen;

  task automatic model_clear();
    m_pending = 0; m_holding = 0;
    m_adr = '0; m_dat = '0; m_we = 0; m_sel = '0; m_buf = '0;
    m_busy_cycles = 0;
  endtask

  task automatic release_bus();
    m_pending = 0;
    m_adr = '0; m_dat = '0; m_we = 0; m_sel = '0;
  endtask

  // One clock: apply inputs, check mid-cycle, then advance the model across the edge.
  task automatic step(input bit r, input bit ce, input bit we, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s, input bit ack,
                      input logic [31:0] rd, input bit st, input bit fl);
    bit          req, tmo, exp_stall;
    logic [31:0] exp_data;
    rst        = r;
    cpu_ce_i   = ce;
    cpu_we_i   = we;
    cpu_addr_i = a;
    cpu_data_i = d;
    cpu_sel_i  = s;
    stall_i    = 6'($urandom);
    stall_i[STALL_IF] = st;
    flush_i    = fl;
    wb.wishbone_ack_i  = ack;
    wb.wishbone_data_i = rd;
    #4;
    req = ce && !fl;
    tmo = TMO_EN && m_pending && !fl && !ack && (m_busy_cycles == TMO);
    if (m_pending) begin
      exp_stall = !(ack || tmo);
      exp_data  = (ack && !m_we) ? rd : 32'h0;
    end else if (m_holding) begin
      exp_stall = 0;
      exp_data  = m_buf;
    end else begin
      exp_stall = req;
      exp_data  = req ? 32'h0 : m_buf;
    end
    check("stallreq", stallreq_o, exp_stall);
    check("cpu_data", cpu_data_o, exp_data);
    check("bus_err", bus_err_o, tmo);
    check("adr", wb.wishbone_addr_o, m_adr);
    check("dat_o", wb.wishbone_data_o, m_dat);
    check("we", wb.wishbone_we_o, m_we);
    check("sel", wb.wishbone_sel_o, m_sel);
    check("stb", wb.wishbone_stb_o, m_pending);
    check("cyc", wb.wishbone_cyc_o, m_pending);
    if (wb.wishbone_stb_o === 1'b1) stb_seen++;
    if (bus_err_o === 1'b1) err_seen++;
    @(posedge clk);
    #1;
    if (r) begin
      model_clear();
    end else if (m_pending) begin
      if (fl) begin
        release_bus();
        m_buf = '0;
      end else if (ack || tmo) begin
        if (tmo)        m_buf = '0;
        else if (!m_we) m_buf = rd;
        release_bus();
        m_holding = st;
      end else begin
        m_busy_cycles++;
      end
    end else if (m_holding) begin
      if (fl) begin
        m_holding = 0;
        m_buf = '0;
      end else if (!st) begin
        m_holding = 0;
      end
    end else if (req) begin
      m_pending = 1;
      m_adr = a; m_dat = d; m_we = we; m_sel = s;
      m_buf = '0;
      m_busy_cycles = 0;
    end
  endtask

  task automatic idle_step(input bit ack, input logic [31:0] rd, input bit st, input bit fl);
    step(0, 0, 0, 32'h0, 32'h0, 4'h0, ack, rd, st, fl);
  endtask

  initial begin
    rst = 1; stall_i = '0; flush_i = 0; cpu_ce_i = 0; cpu_we_i = 0;
    cpu_addr_i = '0; cpu_data_i = '0; cpu_sel_i = '0;
    wb.wishbone_ack_i = 0; wb.wishbone_data_i = '0;
    repeat (2) @(posedge clk);
    #1;
    model_clear();

    // Reset state with a stray ack that must be ignored.
    idle_step(1, 32'h1111_2222, 0, 0);

    // Read, ack on the third BUSY cycle.
    stb_seen = 0;
    step(0, 1, 0, 32'h3000_0010, 32'h0, 4'hF, 0, 32'h0, 0, 0);
    idle_step(0, 32'h0, 0, 0);
    idle_step(0, 32'h0, 0, 0);
    idle_step(1, 32'hDEAD_BEEF, 0, 0);
    idle_step(0, 32'h0, 0, 0);
    check("read_stb_cycles", stb_seen, 3);
    check("read_buf", cpu_data_o, 32'hDEAD_BEEF);

    // Write, sel=0011, ack on the first BUSY cycle.
    step(0, 1, 1, 32'h3000_0020, 32'h1234_5678, 4'b0011, 0, 32'h0, 0, 0);
    check("write_we", wb.wishbone_we_o, 1);
    idle_step(1, 32'h5555_AAAA, 0, 0);
    idle_step(0, 32'h0, 0, 0);

    // Read acked while the IF stage stays stalled for 4 more cycles.
    step(0, 1, 0, 32'h0000_0100, 32'h0, 4'hF, 0, 32'h0, 0, 0);
    idle_step(1, 32'hCAFE_F00D, 1, 0);
    for (int i = 0; i < 4; i++)
      step(0, 1, 0, 32'h0000_0200, 32'h0, 4'hF, 0, 32'h0, 1, 0);
    check("hold_data", cpu_data_o, 32'hCAFE_F00D);
    idle_step(0, 32'h0, 0, 0);

    // Flush in the second BUSY cycle, late ack ignored, clean restart.
    step(0, 1, 0, 32'h0000_0300, 32'h0, 4'hF, 0, 32'h0, 0, 0);
    idle_step(0, 32'h0, 0, 0);
    idle_step(0, 32'h0, 0, 1);
    idle_step(1, 32'hBAD0_BAD0, 0, 0);
    step(0, 1, 0, 32'h0000_0304, 32'h0, 4'hF, 0, 32'h0, 0, 0);
    idle_step(1, 32'h0BAD_F00D, 0, 0);
    idle_step(0, 32'h0, 0, 0);

    // Reset while BUSY.
    step(0, 1, 1, 32'h0000_0400, 32'hFFFF_FFFF, 4'hF, 0, 32'h0, 0, 0);
    idle_step(0, 32'h0, 0, 0);
    step(1, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 0, 0);
    check("rst_stb", wb.wishbone_stb_o, 0);
    check("rst_adr", wb.wishbone_addr_o, 32'h0);
    idle_step(0, 32'h0, 0, 0);

    // Slave that never acks.
    err_seen = 0;
    step(0, 1, 0, 32'h0000_0500, 32'h0, 4'hF, 0, 32'h0, 0, 0);
    for (int i = 0; i < TMO + 4; i++) idle_step(0, 32'h0, 0, 0);
    check("err_pulses", err_seen, TMO_EN ? 1 : 0);
    if (!TMO_EN) step(1, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) == 0),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           $urandom, $urandom, 4'($urandom),
           ($urandom_range(0, 2) == 0),
           $urandom,
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 9) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
